// File: rtl/mem_port_arbiter.sv
// Purpose : two-way arbiter sharing one off-chip memory port between the I-cache and D-cache.
// Latency : request seen in IDLE -> mem strobe next cycle; mem_ready in cycle k -> x_ready/x_rdata in k+1, next strobe no earlier than k+3.
// Backpres: requesters hold read/write until their x_ready pulse; the memory stalls a transaction by withholding mem_ready.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata  I-cache request (held until i_ready)
//   i_rdata/i_ready                I-cache returned line and one-cycle completion pulse
//   d_read/d_write/d_addr/d_wdata  D-cache request (held until d_ready)
//   d_rdata/d_ready                D-cache returned line and one-cycle completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory-side command, held for the whole transaction
//   mem_rdata/mem_ready            memory return line and single-cycle completion pulse
//   grant                          one-hot owner, [0]=I, [1]=D, 00 when idle
//   timeout_err                    sticky watchdog flag, cleared only by rst
module mem_port_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  // Counter wide enough to reach TIMEOUT-1 without wrapping; it saturates.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = I last owned the port, 1 = D
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [1:0]          grant_q, grant_d;

  logic req_i;
  logic req_d;
  logic pick_d;

  always_comb begin
    req_i = i_read | i_write;
    req_d = d_read | d_write;
    // D wins if it is the only requester, or on a tie when I owned the port last.
    pick_d = req_d & (~req_i | ~last_grant_q);

    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ready_d     = i_ready_q;
    d_ready_d     = d_ready_q;
    grant_d       = grant_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i | req_d) begin
          cnt_d = '0;
          if (pick_d) begin
            state_d      = ST_BUSY_D;
            grant_d      = 2'b10;
            last_grant_d = 1'b1;
            // Write has priority when both read and write are asserted.
            mem_write_d  = d_write;
            mem_read_d   = d_read & ~d_write;
            mem_addr_d   = d_addr;
            mem_wdata_d  = d_wdata;
          end else begin
            state_d      = ST_BUSY_I;
            grant_d      = 2'b01;
            last_grant_d = 1'b0;
            mem_write_d  = i_write;
            mem_read_d   = i_read & ~i_write;
            mem_addr_d   = i_addr;
            mem_wdata_d  = i_wdata;
          end
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_DONE;
          if (state_q == ST_BUSY_I) begin
            i_ready_d = 1'b1;
            if (mem_read_q) begin
              i_rdata_d = mem_rdata;
            end
          end else begin
            d_ready_d = 1'b1;
            if (mem_read_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // The transaction keeps waiting; the flag only reports the stall.
          if (WDOG_EN && (cnt_d >= TO_LIMIT)) begin
            timeout_err_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // Owner's request is stale here, so no arbitration this cycle.
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        grant_d   = 2'b00;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      grant_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_ready_q     <= i_ready_d;
      d_ready_q     <= d_ready_d;
      grant_q       <= grant_d;
    end
  end

  assign i_rdata     = i_rdata_q;
  assign i_ready     = i_ready_q;
  assign d_rdata     = d_rdata_q;
  assign d_ready     = d_ready_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

  // Structural invariants of the arbiter.
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  a_ready_excl:   assert property (@(posedge clk) disable iff (rst) !(i_ready_q && d_ready_q));
  a_op_excl:      assert property (@(posedge clk) disable iff (rst) !(mem_read_q && mem_write_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter with a behavioural memory and per-requester scoreboards.
// Latency : memory answers after mem_lat BUSY cycles unless mem_hang is set.
// Backpres: bench requesters hold their request until the matching ready pulse.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write, mem_ready, timeout_err;
  logic [1:0]    grant;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_d;
    bit          rd;
    bit          wr;
    logic [27:0] addr;
    logic [127:0] wdata;
    int          lat;
    bit          exp_mrd;
    bit          exp_mwr;
    logic [1:0]  exp_grant;
  } vec_t;

  vec_t vt[7];

  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] last_i, last_d;

  int  mem_lat  = 3;
  bit  mem_hang = 1'b0;
  int  busy_cnt = 0;

  logic [1:0] glog[$];
  logic [1:0] prev_g;
  logic [1:0] exp_g;
  int         done_cnt;
  int         n_lat;
  bit         ok;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 28'h0000010) return {16{8'hA5}};
    return {4{a, 4'h5}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line for one completion; a write leaves rdata at the last read value.
  task automatic push_exp(input bit is_d, input bit wr, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    if (is_d) begin
      e = wr ? last_d : line_of(a);
      if (!wr) last_d = e;
      exp_d_q.push_back(e);
    end else begin
      e = wr ? last_i : line_of(a);
      if (!wr) last_i = e;
      exp_i_q.push_back(e);
    end
  endtask

  task automatic wait_rdy(input bit is_d, input string name, output int n, output bit found);
    found = 1'b0;
    n = 0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (is_d ? d_ready : i_ready) begin
        n = c;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: ready not seen within 64 cycles", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    exp_i_q.delete();
    exp_d_q.delete();
    last_i = '0;
    last_d = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    bit  f;
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_read = v.rd; i_write = v.wr; i_addr = v.addr; i_wdata = v.wdata;
    end
    mem_lat = v.lat;
    push_exp(v.is_d, v.wr, v.addr);
    check($sformatf("v%0d_no_strobe_yet", idx), {mem_read, mem_write}, 2'b00);
    tick();
    check($sformatf("v%0d_mem_read", idx), mem_read, v.exp_mrd);
    check($sformatf("v%0d_mem_write", idx), mem_write, v.exp_mwr);
    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
    check($sformatf("v%0d_grant", idx), grant, v.exp_grant);
    wait_rdy(v.is_d, $sformatf("v%0d_ready", idx), n, f);
    if (v.is_d) begin d_read = 0; d_write = 0; end
    else begin i_read = 0; i_write = 0; end
    if (f) begin
      check($sformatf("v%0d_latency", idx), n, v.lat);
      check($sformatf("v%0d_done_grant", idx), grant, v.exp_grant);
      tick();
      check($sformatf("v%0d_ready_pulse", idx), {i_ready, d_ready}, 2'b00);
      check($sformatf("v%0d_idle_grant", idx), grant, 2'b00);
    end
  endtask

  // Behavioural memory: answers after mem_lat BUSY cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      tick();
      mem_ready = 1'b0;
      if (rst || !(mem_read || mem_write)) begin
        busy_cnt = 0;
      end else begin
        busy_cnt++;
        if (!mem_hang && busy_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(mem_addr);
          busy_cnt  = 0;
        end
      end
    end
  end

  // Scoreboard compare on completion pulses.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      if (i_ready) begin
        if (exp_i_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL i_ready_unexpected: pulse with empty scoreboard");
        end else begin
          e = exp_i_q.pop_front();
          check("i_rdata", i_rdata, e);
        end
      end
      if (d_ready) begin
        if (exp_d_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d_ready_unexpected: pulse with empty scoreboard");
        end else begin
          e = exp_d_q.pop_front();
          check("d_rdata", d_rdata, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vt[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h11112222333344445555666677778888, 3, 1'b1, 1'b0, 2'b01};
    vt[1] = '{1'b1, 1'b1, 1'b0, 28'h0ABCDEF, 128'h0, 1, 1'b1, 1'b0, 2'b10};
    vt[2] = '{1'b0, 1'b0, 1'b1, 28'h0000020, 128'hDEADBEEFCAFEF00D0123456789ABCDEF, 2, 1'b0, 1'b1, 2'b01};
    vt[3] = '{1'b1, 1'b0, 1'b1, 28'hFFFFFFF, {128{1'b1}}, 5, 1'b0, 1'b1, 2'b10};
    vt[4] = '{1'b1, 1'b1, 1'b1, 28'h0000044, 128'h00000000FFFFFFFF00000000FFFFFFFF, 2, 1'b0, 1'b1, 2'b10};
    vt[5] = '{1'b0, 1'b1, 1'b0, 28'h0000000, 128'h5A5A, 4, 1'b1, 1'b0, 2'b01};
    vt[6] = '{1'b1, 1'b1, 1'b0, 28'h0FFFFFF, 128'h1, 3, 1'b1, 1'b0, 2'b10};

    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    do_reset();

    // Reset state
    check("rst_mem_strobes", {mem_read, mem_write}, 2'b00);
    check("rst_grant", grant, 2'b00);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_rdata", {i_rdata, d_rdata}, '0);
    check("rst_mem_addr", mem_addr, '0);

    // First tie after reset goes to D, then I three cycles after D's mem_ready edge
    mem_lat = 3;
    i_read = 1; i_addr = 28'h0000080; d_read = 1; d_addr = 28'h0000090;
    push_exp(0, 0, 28'h0000080);
    push_exp(1, 0, 28'h0000090);
    tick();
    check("tie_grant_d", grant, 2'b10);
    check("tie_mem_addr_d", mem_addr, 28'h0000090);
    wait_rdy(1, "tie_d_ready", n_lat, ok);
    d_read = 0;
    if (ok) begin
      check("tie_done_strobe", mem_read, 1'b0);
      tick();
      check("tie_idle_grant", grant, 2'b00);
      check("tie_idle_strobe", mem_read, 1'b0);
      tick();
      check("tie_i_strobe", mem_read, 1'b1);
      check("tie_grant_i", grant, 2'b01);
      check("tie_mem_addr_i", mem_addr, 28'h0000080);
    end
    wait_rdy(0, "tie_i_ready", n_lat, ok);
    i_read = 0;
    tick();

    // Single-requester transactions
    for (int k = 0; k < 7; k++) begin
      run_vec(k, vt[k]);
    end

    // D write-back, with a read raised by the D-cache while BUSY_D
    mem_lat = 4;
    d_write = 1; d_read = 0; d_addr = 28'h1234567; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    push_exp(1, 1, 28'h1234567);
    tick();
    check("wb_mem_write", mem_write, 1'b1);
    check("wb_mem_read", mem_read, 1'b0);
    check("wb_mem_addr", mem_addr, 28'h1234567);
    check("wb_mem_wdata", mem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    d_write = 0; d_read = 1; d_addr = 28'h0000300; d_wdata = '0;
    push_exp(1, 0, 28'h0000300);
    tick();
    check("wb_hold_ops", {mem_read, mem_write}, 2'b01);
    check("wb_hold_addr", mem_addr, 28'h1234567);
    check("wb_hold_wdata", mem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    wait_rdy(1, "wb_ready", n_lat, ok);
    tick();
    check("wb_idle_grant", grant, 2'b00);
    tick();
    check("wb_rd_strobe", {mem_read, mem_write}, 2'b10);
    check("wb_rd_addr", mem_addr, 28'h0000300);
    check("wb_rd_grant", grant, 2'b10);
    wait_rdy(1, "wb_rd_ready", n_lat, ok);
    d_read = 0;
    tick();

    // Continuous contention: six transactions strictly alternating D,I,...
    do_reset();
    mem_lat = 2;
    i_read = 1; i_addr = 28'h0000100; d_read = 1; d_addr = 28'h0000200;
    for (int k = 0; k < 3; k++) begin
      push_exp(0, 0, 28'h0000100);
      push_exp(1, 0, 28'h0000200);
    end
    done_cnt = 0;
    prev_g = 2'b00;
    glog.delete();
    for (int c = 0; c < 200 && done_cnt < 6; c++) begin
      tick();
      if (grant != prev_g && grant != 2'b00) glog.push_back(grant);
      prev_g = grant;
      if (i_ready || d_ready) begin
        done_cnt++;
        if (done_cnt == 6) begin
          i_read = 0;
          d_read = 0;
        end
      end
    end
    tick();
    check("cont_done", done_cnt, 6);
    check("cont_grant_count", glog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      check($sformatf("cont_grant_%0d", k), (k < glog.size()) ? glog[k] : 2'b00, exp_g);
    end
    check("cont_idle", grant, 2'b00);

    // Watchdog: memory stalls, flag after the 7th BUSY cycle, sticky after completion
    mem_hang = 1'b1;
    mem_lat = 3;
    i_read = 1; i_addr = 28'h0000040;
    push_exp(0, 0, 28'h0000040);
    tick();
    repeat (6) tick();
    check("wd_busy7_strobe", mem_read, 1'b1);
    check("wd_busy7_flag", timeout_err, 1'b0);
    tick();
    check("wd_busy8_flag", timeout_err, 1'b1);
    mem_hang = 1'b0;
    wait_rdy(0, "wd_ready", n_lat, ok);
    i_read = 0;
    check("wd_flag_at_done", timeout_err, 1'b1);
    repeat (3) tick();
    check("wd_flag_sticky", timeout_err, 1'b1);

    // Asynchronous reset in the middle of BUSY_I
    mem_lat = 5;
    i_read = 1; i_addr = 28'h0000060;
    tick();
    check("ar_busy_strobe", mem_read, 1'b1);
    check("ar_busy_grant", grant, 2'b01);
    tick();
    #2;
    rst = 1'b1;
    exp_i_q.delete();
    exp_d_q.delete();
    last_i = '0;
    last_d = '0;
    #1;
    check("ar_mem_read", mem_read, 1'b0);
    check("ar_grant", grant, 2'b00);
    check("ar_i_ready", i_ready, 1'b0);
    check("ar_timeout_clr", timeout_err, 1'b0);
    tick();
    rst = 1'b0;
    d_read = 1; d_addr = 28'h0000070;
    push_exp(0, 0, 28'h0000060);
    push_exp(1, 0, 28'h0000070);
    tick();
    check("ar_tie_grant_d", grant, 2'b10);
    wait_rdy(1, "ar_d_ready", n_lat, ok);
    d_read = 0;
    wait_rdy(0, "ar_i_ready_done", n_lat, ok);
    i_read = 0;
    tick();

    check("sb_i_empty", exp_i_q.size(), 0);
    check("sb_d_empty", exp_d_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
